// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stage enables, flushes, halt drain sequencing
// and saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       ex_writeReg,
  input  logic             ex_dmemREN,
  input  logic             mem_dmemREN,
  input  logic             mem_dmemWEN,
  input  logic             ex_branch_taken,
  input  logic             id_jump,
  input  logic             mem_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} state_t;

  state_t           state_q, state_d;
  logic [3:0]       drain_q, drain_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             dmem_miss, load_use, stall_evt, flush_evt;

  assign dmem_miss = (mem_dmemREN | mem_dmemWEN) & ~dhit;
  assign load_use  = ex_dmemREN && (ex_writeReg != 5'd0) &&
                     ((ex_writeReg == id_rs) || (ex_writeReg == id_rt));

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    flush_evt   = 1'b0;

    if (RST) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      {ifid_flush, idex_flush, exmem_flush}         = 3'b111;
    end else if (state_q == HALTED) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
    end else if (state_q == DRAIN) begin
      pc_en                                 = 1'b0;
      {ifid_flush, idex_flush, exmem_flush} = 3'b111;
      if (drain_q == 4'd0) state_d = HALTED;
      else                 drain_d = drain_q - 4'd1;
    end else if (mem_halt) begin
      pc_en                                 = 1'b0;
      {ifid_flush, idex_flush, exmem_flush} = 3'b111;
      drain_d                               = 4'(DRAIN_CYCLES - 1);
      state_d                               = DRAIN;
    end else if (dmem_miss) begin
      // Frozen pipe: control hazards are re-evaluated once the miss clears.
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      state_d                                       = DWAIT;
    end else begin
      state_d = RUN;
      if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        flush_evt  = 1'b1;
      end else if (!ihit) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (id_jump) begin
        ifid_flush = 1'b1;
        flush_evt  = 1'b1;
      end
    end

    halted    = (state_q == HALTED) && !RST;
    stall_evt = !pc_en && !halted && (state_q != DRAIN);

    stall_cnt_d = stall_cnt_q;
    if (stall_evt && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    flush_cnt_d = flush_cnt_q;
    if (flush_evt && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      drain_q     <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: behavioural model compared every cycle,
// directed scenarios with literal expectations, randomized traffic, saturation.
module tb_hazard_ctrl;

  localparam int DRAIN_CYCLES = 2;
  localparam int CNT_W        = 16;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             ihit = 1'b1, dhit = 1'b1;
  logic [4:0]       id_rs = '0, id_rt = '0, ex_writeReg = '0;
  logic             ex_dmemREN = 1'b0, mem_dmemREN = 1'b0, mem_dmemWEN = 1'b0;
  logic             ex_branch_taken = 1'b0, id_jump = 1'b0, mem_halt = 1'b0;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, exmem_flush, halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int passes = 0;

  // Model state: remaining drain cycles (0 = not draining), halted flag, counters.
  int m_drain_left = 0;
  bit m_halted     = 1'b0;
  int m_stall      = 0;
  int m_flush      = 0;

  hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .id_rs(id_rs), .id_rt(id_rt), .ex_writeReg(ex_writeReg),
    .ex_dmemREN(ex_dmemREN), .mem_dmemREN(mem_dmemREN), .mem_dmemWEN(mem_dmemWEN),
    .ex_branch_taken(ex_branch_taken), .id_jump(id_jump), .mem_halt(mem_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model compare + update, once per cycle on the falling edge.
  always @(negedge CLK) begin : model_cmp
    logic [8:0] exp_v, act_v;
    bit         miss, lu, flush_evt, draining;
    miss      = (mem_dmemREN || mem_dmemWEN) && !dhit;
    lu        = ex_dmemREN && ex_writeReg != 0 && (ex_writeReg == id_rs || ex_writeReg == id_rt);
    draining  = m_drain_left > 0;
    flush_evt = 1'b0;
    // Vector: pc, ifid, idex, exmem, memwb enables | ifid, idex, exmem flushes | halted
    if (RST)                         exp_v = 9'b00000_111_0;
    else if (m_halted)               exp_v = 9'b00000_000_1;
    else if (draining || mem_halt)   exp_v = 9'b01111_111_0;
    else if (miss)                   exp_v = 9'b00000_000_0;
    else if (ex_branch_taken) begin  exp_v = 9'b11111_110_0; flush_evt = 1'b1; end
    else if (!ihit)                  exp_v = 9'b01111_100_0;
    else if (lu)                     exp_v = 9'b00111_010_0;
    else if (id_jump) begin          exp_v = 9'b11111_100_0; flush_evt = 1'b1; end
    else                             exp_v = 9'b11111_000_0;

    act_v = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, halted};
    check_output("model_outputs", 32'(act_v), 32'(exp_v));
    check_output("model_stall_cnt", 32'(stall_cnt), m_stall);
    check_output("model_flush_cnt", 32'(flush_cnt), m_flush);

    if (RST) begin
      m_drain_left = 0; m_halted = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      if (!exp_v[8] && !m_halted && !draining && m_stall < CNT_MAX) m_stall++;
      if (flush_evt && m_flush < CNT_MAX) m_flush++;
      if (draining) begin
        m_drain_left--;
        if (m_drain_left == 0) m_halted = 1'b1;
      end else if (!m_halted && mem_halt) begin
        m_drain_left = DRAIN_CYCLES;
      end
    end
  end

  task automatic apply_stimulus(input logic rst, input logic ih, input logic dh,
                                input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wr,
                                input logic exren, input logic mren, input logic mwen,
                                input logic br, input logic jmp, input logic hlt);
    @(posedge CLK); #1;
    RST = rst; ihit = ih; dhit = dh; id_rs = rs; id_rt = rt; ex_writeReg = wr;
    ex_dmemREN = exren; mem_dmemREN = mren; mem_dmemWEN = mwen;
    ex_branch_taken = br; id_jump = jmp; mem_halt = hlt;
  endtask

  task automatic idle(input logic rst);
    apply_stimulus(rst, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset outputs
    idle(1'b1);
    @(negedge CLK);
    check_output("rst_pc_en", pc_en, 0);
    check_output("rst_flushes", {ifid_flush, idex_flush, exmem_flush}, 3'b111);
    check_output("rst_halted", halted, 0);
    idle(1'b0);
    @(negedge CLK);
    check_output("idle_pc_en", pc_en, 1);
    check_output("idle_stall_cnt", stall_cnt, 0);

    // Load-use stall, then $zero destination never stalls
    apply_stimulus(0, 1, 1, 8, 3, 8, 1, 0, 0, 0, 0, 0);
    @(negedge CLK);
    check_output("lu_ctrl", {pc_en, ifid_en, idex_flush}, 3'b001);
    apply_stimulus(0, 1, 1, 0, 3, 0, 1, 0, 0, 0, 0, 0);
    @(negedge CLK);
    check_output("lu_stall_cnt", stall_cnt, 1);
    check_output("lu_zero_pc_en", pc_en, 1);

    // Data miss for three cycles, then hit
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      @(negedge CLK);
      check_output("dmiss_enables", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 0);
    end
    apply_stimulus(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    @(negedge CLK);
    check_output("dhit_enables", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b11111);
    idle(1'b0);
    @(negedge CLK);
    check_output("dmiss_stall_cnt", stall_cnt, 4);

    // Branch beats imiss and load-use
    apply_stimulus(0, 0, 1, 8, 0, 8, 1, 0, 0, 1, 0, 0);
    @(negedge CLK);
    check_output("br_ctrl", {pc_en, ifid_flush, idex_flush}, 3'b111);
    idle(1'b0);
    @(negedge CLK);
    check_output("br_flush_cnt", flush_cnt, 1);

    // Reset in the middle of a data miss
    apply_stimulus(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    apply_stimulus(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(1'b0);
    @(negedge CLK);
    check_output("rst_dwait_pc_en", pc_en, 1);
    check_output("rst_dwait_cnts", {stall_cnt, flush_cnt}, 0);

    // Halt: halted rises on the third edge after the halt cycle
    apply_stimulus(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge CLK);
    check_output("halt_c0", {pc_en, halted}, 2'b00);
    idle(1'b0);
    @(negedge CLK);
    check_output("halt_c1", halted, 0);
    apply_stimulus(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    @(negedge CLK);
    check_output("halt_c2", halted, 0);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(0, 1'($urandom), 1'($urandom), 0, 0, 0, 0, 0, 0, 1'($urandom), 1'($urandom), 0);
      @(negedge CLK);
      check_output("halted_state", {pc_en, ifid_en, idex_en, exmem_en, memwb_en, halted}, 6'b000001);
    end
    idle(1'b1);
    idle(1'b0);
    @(negedge CLK);
    check_output("halt_rst_pc_en", {pc_en, halted}, 2'b10);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                     $urandom_range(0, 2) != 0,
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                     $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                     $urandom_range(0, 7) == 0, $urandom_range(0, 149) == 0);
    end

    // Stall counter saturation
    idle(1'b1);
    apply_stimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (70000) @(posedge CLK);
    @(negedge CLK);
    check_output("stall_saturate", stall_cnt, 16'hFFFF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
